button_step_gen: RTL and testbench
==================================

// Module: button_step_gen
// PURPOSE
// - Upstream stage for the LED counter: converts a raw, bouncing, active-low board button
//   into clean one-cycle step pulses that advance the counter.
// - Synchronises and debounces the input, emits one step per press, and auto-repeats
//   while the button is held.
// - Sits between the board button pin and the counter's enable/step input.
// PARAMETERS
// DEBOUNCE_CYC      270000    cycles btn_n must be stable before a level change is accepted (10 ms @ 27 MHz)
// REPEAT_DELAY_CYC  13500000  cycles from the first step to the first auto-repeat step (0.5 s)
// REPEAT_RATE_CYC   2700000   cycles between later auto-repeat steps (0.1 s)
// REPEAT_EN         1         1 = auto-repeat enabled; 0 = exactly one step per press
// PORTS
// clk    in   1  system clock (27 MHz)
// rst    in   1  synchronous, active-high reset
// btn_n  in   1  raw button pin, active-low, asynchronous to clk
// step   out  1  one-cycle pulse: advance counter by one
// pressed out 1  debounced button level, 1 = pressed
// held   out  1  1 while in auto-repeat phase
// BEHAVIOUR
// - Reset: step=0, pressed=0, held=0; sync FFs=1 (released); all counters=0; FSM=IDLE.
// - Sync: two FFs. At edge n btn_n is captured into s1; at edge n+1 it moves into s2.
// - Debounce: counter cnt, width $clog2(DEBOUNCE_CYC+1).
//   - Each edge with s2==db: cnt<=0.
//   - Each edge with s2!=db: cnt<=cnt+1; if cnt==DEBOUNCE_CYC-1, then db<=s2 and cnt<=0.
//   - pressed = ~db (registered).
//   - Result: a clean level change sampled at edge n updates pressed at edge n+1+DEBOUNCE_CYC.
//   - Any single cycle of disagreement restarts the count.
// - FSM states: IDLE, FIRST, WAIT, REPEAT. Registered step is asserted exactly 1 cycle per event.
//   - IDLE: pressed==1 -> step<=1, tmr<=0, go FIRST (step at edge n+2+DEBOUNCE_CYC).
//   - FIRST/WAIT: tmr counts up each edge.
//     - If tmr==REPEAT_DELAY_CYC-1 and REPEAT_EN: step<=1, tmr<=0, held<=1, go REPEAT.
//     - If REPEAT_EN==0: stay in WAIT until release.
//   - REPEAT: tmr counts; tmr==REPEAT_RATE_CYC-1 -> step<=1, tmr<=0.
//   - Any state: pressed==0 -> go IDLE, held<=0, tmr<=0, no step. Release never produces a step.
// - Timer width: $clog2(max(REPEAT_DELAY_CYC,REPEAT_RATE_CYC)+1).
//   - Timers saturate at their compare point; they never wrap.
// - Simultaneous events: release takes priority over a timer expiry in the same cycle.
//   No step is emitted.
// - Reset mid-operation: outputs are 0 after the reset edge.
//   - A button still held after reset is re-debounced from the released state.
//   - It yields a fresh first step DEBOUNCE_CYC+3 edges after rst deasserts.
// - step never asserts on two consecutive cycles.
// TESTING (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, REPEAT_EN=1)
// 1. rst=1 for 3 cycles, btn_n=1 -> step=0, pressed=0, held=0 on every cycle.
// 2. btn_n=0 sampled first at edge 0, held 8 cycles, then released -> pressed=1 after edge 5.
//    Exactly one step, high after edge 6. No step on release. pressed=0 after edge 5+8.
// 3. Bounce: btn_n low 3 cycles, high 1, low 3, high -> pressed stays 0, no step.
// 4. Hold 30 cycles starting at edge 0 -> steps after edges 6, 16, 19, 22, 25, 28, 31, 34.
//    held=1 from edge 16 until release.
// 5. During hold (REPEAT), btn_n glitches high 2 cycles -> pressed stays 1, held stays 1,
//    repeat cadence unchanged.
// 6. rst pulsed 1 cycle mid-REPEAT with btn_n held low -> all outputs 0 next cycle.
//    Next step occurs 7 edges after rst deasserts. Repeat restarts with a 10-cycle delay.

Source files
------------

// File: rtl/button_step_gen.sv
// rtl/button_step_gen.sv - button synchroniser, debouncer and step/auto-repeat pulse generator
// Turns a raw active-low button into one-cycle step pulses, with auto-repeat while the button is held.
module button_step_gen #(
  parameter int DEBOUNCE_CYC     = 270000,
  parameter int REPEAT_DELAY_CYC = 13500000,
  parameter int REPEAT_RATE_CYC  = 2700000,
  parameter bit REPEAT_EN        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic step,
  output logic pressed,
  output logic held
);

  localparam int CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int TMR_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             db;
  logic [TMR_W-1:0] tmr;
  state_t           state;

  // Debounced level is kept as 'pressed'; the released-high view is its inverse.
  assign db = ~pressed;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        pressed <= ~s2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Release is tested first so it always wins over a timer expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tmr   <= '0;
      step  <= 1'b0;
      held  <= 1'b0;
    end else begin
      step <= 1'b0;
      if (!pressed) begin
        state <= ST_IDLE;
        tmr   <= '0;
        held  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            step  <= 1'b1;
            tmr   <= '0;
            state <= ST_FIRST;
          end
          ST_FIRST, ST_WAIT: begin
            if (REPEAT_EN && (tmr == DELAY_LAST)) begin
              step  <= 1'b1;
              tmr   <= '0;
              held  <= 1'b1;
              state <= ST_REPEAT;
            end else begin
              state <= ST_WAIT;
              if (tmr != DELAY_LAST) begin
                tmr <= tmr + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (tmr == RATE_LAST) begin
              step <= 1'b1;
              tmr  <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            tmr   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_step_gen.sv
// tb/tb_button_step_gen.sv - directed self-checking bench for button_step_gen
module tb_button_step_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic step;
  logic pressed;
  logic held;

  int checks = 0;
  int errors = 0;

  button_step_gen #(
    .DEBOUNCE_CYC    (4),
    .REPEAT_DELAY_CYC(10),
    .REPEAT_RATE_CYC (3),
    .REPEAT_EN       (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_n  (btn_n),
    .step   (step),
    .pressed(pressed),
    .held   (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives inputs for edge e, lets the edge happen, then checks the outputs settled after it.
  task automatic cycle(input logic b, input logic r, input string tag, input int e,
                       input int e_step, input int e_pr, input int e_held);
    btn_n = b;
    rst   = r;
    @(posedge clk);
    #1;
    check($sformatf("%s e%0d step", tag, e), int'(step), e_step);
    check($sformatf("%s e%0d pressed", tag, e), int'(pressed), e_pr);
    check($sformatf("%s e%0d held", tag, e), int'(held), e_held);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      btn_n = 1'b1;
      rst   = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Hold for 30 edges, optionally with a 2-cycle high glitch in the repeat phase.
  task automatic run_hold(input bit glitch, input string tag);
    bit b;
    int es;
    for (int e = 0; e <= 40; e++) begin
      b  = (e >= 30) || (glitch && (e == 20 || e == 21));
      es = (e == 6 || e == 16 || e == 19 || e == 22 || e == 25 ||
            e == 28 || e == 31 || e == 34) ? 1 : 0;
      cycle(b, 1'b0, tag, e, es, (e >= 5 && e < 35) ? 1 : 0, (e >= 16 && e <= 35) ? 1 : 0);
    end
  endtask

  initial begin
    for (int e = 0; e < 3; e++) begin
      cycle(1'b1, 1'b1, "reset", e, 0, 0, 0);
    end
    idle(10);

    for (int e = 0; e <= 20; e++) begin
      cycle((e < 8) ? 1'b0 : 1'b1, 1'b0, "press", e, (e == 6) ? 1 : 0,
            (e >= 5 && e < 13) ? 1 : 0, 0);
    end
    idle(10);

    for (int e = 0; e <= 15; e++) begin
      cycle((e <= 2 || (e >= 4 && e <= 6)) ? 1'b0 : 1'b1, 1'b0, "bounce", e, 0, 0, 0);
    end
    idle(10);

    run_hold(1'b0, "hold");
    idle(15);
    run_hold(1'b1, "glitch");
    idle(15);

    for (int e = 0; e <= 46; e++) begin
      int es;
      int ep;
      int eh;
      es = (e == 6 || e == 16 || e == 19 || e == 22 || e == 31 || e == 41 || e == 44) ? 1 : 0;
      ep = ((e >= 5 && e < 24) || e >= 30) ? 1 : 0;
      eh = ((e >= 16 && e < 24) || e >= 41) ? 1 : 0;
      cycle(1'b0, (e == 24) ? 1'b1 : 1'b0, "midrst", e, es, ep, eh);
    end
    idle(15);
    check("final_idle step", int'(step), 0);
    check("final_idle pressed", int'(pressed), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
